cps2_sync_lock_ctrl: RTL

Monitors the raw CPS2 HSYNC/VSYNC stream feeding cps2_frontend. It measures line period in PCLK cycles and lines per frame, and runs a lock state machine. It gates the frontend output path (frontend_en_o) so that the downstream scaler/HDMI path only sees video once the source timing is stable. It sits beside cps2_frontend on the same PCLK and sync inputs; its status is readable by the control CPU.

---
 rtl/cps2_sync_lock_ctrl.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cps2_sync_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cps2_sync_lock_ctrl
//  Purpose  : Measures the CPS2 line period and the number of lines per frame
//             from the raw HSYNC/VSYNC stream. A lock state machine uses these
//             measurements to decide when the frontend output path may be
//             enabled.
//  Revision : 1.0  initial release
// ============================================================================
module cps2_sync_lock_ctrl #(
    parameter int unsigned H_TOTAL_EXP   = 1024,
    parameter int unsigned H_TOL         = 4,
    parameter int unsigned V_TOTAL_EXP   = 262,
    parameter int unsigned V_TOL         = 2,
    parameter int unsigned LOCK_FRAMES   = 4,
    parameter int unsigned UNLOCK_MISSES = 2
) (
    input  logic        PCLK_i,
    input  logic        reset_n,
    input  logic        HSYNC_i,
    input  logic        VSYNC_i,
    output logic        lock_o,
    output logic        frontend_en_o,
    output logic [1:0]  state_o,
    output logic [11:0] h_period_o,
    output logic [9:0]  v_lines_o,
    output logic        frame_err_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [11:0] HCNT_MAX = 12'hFFF;
    localparam logic [9:0]  VCNT_MAX = 10'h3FF;

    // Acceptance windows, computed one bit wider so the upper bound
    // cannot wrap around.
    localparam logic [12:0] H_HI = 13'(H_TOTAL_EXP + H_TOL);
    localparam logic [12:0] H_LO = (H_TOL >= H_TOTAL_EXP) ? 13'd0
                                                         : 13'(H_TOTAL_EXP - H_TOL);
    localparam logic [10:0] V_HI = 11'(V_TOTAL_EXP + V_TOL);
    localparam logic [10:0] V_LO = (V_TOL >= V_TOTAL_EXP) ? 11'd0
                                                         : 11'(V_TOTAL_EXP - V_TOL);

    // Counter values at which the next good/bad frame completes the
    // lock or unlock decision.
    localparam logic [7:0] GOOD_LAST = 8'(LOCK_FRAMES - 1);
    localparam logic [7:0] MISS_LAST = 8'(UNLOCK_MISSES - 1);

    typedef enum logic [1:0] {
        NOSYNC  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Internal state
    // ------------------------------------------------------------------------
    state_t      state;
    logic        hs_prev;     // HSYNC_i delayed by one PCLK
    logic        ls;          // registered line start (falling HSYNC edge)
    logic        vs_smp;      // VSYNC_i captured together with the HSYNC edge
    logic        vs_prev;     // VSYNC level seen at the previous line start
    logic [11:0] hcnt;
    logic [9:0]  vcnt;
    logic        line_err;    // sticky: a bad line was seen in this frame
    logic [7:0]  good_ctr;
    logic [7:0]  miss_ctr;

    // ------------------------------------------------------------------------
    // Combinational measurement and check terms
    // ------------------------------------------------------------------------
    logic        fs;
    logic        timeout;
    logic [11:0] hm;
    logic [9:0]  vm;
    logic        line_bad;
    logic        vlines_bad;
    logic        frame_bad;
    logic        evaluate;

    // A frame starts on the line whose edge sees VSYNC newly asserted (low).
    assign fs = ls & vs_prev & ~vs_smp;

    // A saturated line counter means HSYNC has gone missing.
    assign timeout = (hcnt == HCNT_MAX);

    // Measured period and line count include the closing edge itself.
    assign hm = (hcnt == HCNT_MAX) ? HCNT_MAX : hcnt + 12'd1;
    assign vm = (vcnt == VCNT_MAX) ? VCNT_MAX : vcnt + 10'd1;

    assign line_bad   = ({1'b0, hm} > H_HI) || ({1'b0, hm} < H_LO);
    assign vlines_bad = ({1'b0, vm} > V_HI) || ({1'b0, vm} < V_LO);

    // The line closed by the frame-start edge belongs to the frame being
    // judged, so its check is folded in alongside the sticky flag.
    assign frame_bad = line_err | line_bad | vlines_bad;

    // The frame that ends on the first frame start after NOSYNC is partial
    // and is therefore never judged.
    assign evaluate = fs & ~timeout & (state != NOSYNC);

    // ------------------------------------------------------------------------
    // Edge detection: register HSYNC once and register the edge strobe so all
    // downstream logic works from flops only.
    // ------------------------------------------------------------------------
    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev <= 1'b0;
            ls      <= 1'b0;
            vs_smp  <= 1'b0;
        end else begin
            hs_prev <= HSYNC_i;
            ls      <= hs_prev & ~HSYNC_i;
            vs_smp  <= VSYNC_i;
        end
    end

    // ------------------------------------------------------------------------
    // Line period counter and last-period capture.
    // ------------------------------------------------------------------------
    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            hcnt       <= 12'd0;
            h_period_o <= 12'd0;
        end else begin
            if (ls) begin
                hcnt <= 12'd0;
            end else if (hcnt != HCNT_MAX) begin
                hcnt <= hcnt + 12'd1;
            end

            // A lost HSYNC reports the saturated period and wins over any
            // edge arriving at the same time.
            if (timeout) begin
                h_period_o <= HCNT_MAX;
            end else if (ls) begin
                h_period_o <= hm;
            end
        end
    end

    // ------------------------------------------------------------------------
    // VSYNC history, lines-per-frame counter and the sticky bad-line flag.
    // ------------------------------------------------------------------------
    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            vs_prev   <= 1'b0;
            vcnt      <= 10'd0;
            v_lines_o <= 10'd0;
            line_err  <= 1'b0;
        end else begin
            if (ls) begin
                vs_prev <= vs_smp;
            end

            if (fs) begin
                vcnt      <= 10'd0;
                v_lines_o <= vm;
                line_err  <= 1'b0;
            end else if (ls) begin
                vcnt     <= vm;
                line_err <= line_err | line_bad;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Lock state machine with registered status outputs; all transitions
    // happen on frame starts except the HSYNC-loss timeout.
    // ------------------------------------------------------------------------
    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            state         <= NOSYNC;
            good_ctr      <= 8'd0;
            miss_ctr      <= 8'd0;
            lock_o        <= 1'b0;
            frontend_en_o <= 1'b0;
            frame_err_o   <= 1'b0;
        end else begin
            frame_err_o <= evaluate & frame_bad;

            if (timeout) begin
                state         <= NOSYNC;
                good_ctr      <= 8'd0;
                miss_ctr      <= 8'd0;
                lock_o        <= 1'b0;
                frontend_en_o <= 1'b0;
            end else if (fs) begin
                case (state)
                    NOSYNC: begin
                        state    <= ACQUIRE;
                        good_ctr <= 8'd0;
                    end

                    ACQUIRE: begin
                        if (frame_bad) begin
                            good_ctr <= 8'd0;
                        end else if (good_ctr >= GOOD_LAST) begin
                            state         <= LOCKED;
                            good_ctr      <= 8'd0;
                            lock_o        <= 1'b1;
                            frontend_en_o <= 1'b1;
                        end else begin
                            good_ctr <= good_ctr + 8'd1;
                        end
                    end

                    LOCKED: begin
                        if (frame_bad) begin
                            state    <= HOLD;
                            miss_ctr <= 8'd1;
                        end
                    end

                    HOLD: begin
                        if (!frame_bad) begin
                            state    <= LOCKED;
                            miss_ctr <= 8'd0;
                        end else if (miss_ctr >= MISS_LAST) begin
                            state         <= ACQUIRE;
                            good_ctr      <= 8'd0;
                            miss_ctr      <= 8'd0;
                            lock_o        <= 1'b0;
                            frontend_en_o <= 1'b0;
                        end else begin
                            miss_ctr <= miss_ctr + 8'd1;
                        end
                    end

                    default: begin
                        state         <= NOSYNC;
                        lock_o        <= 1'b0;
                        frontend_en_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state_o = state;

endmodule
`default_nettype wire
